// File: rtl/alu_sched_pkg.sv
// Shared state encoding and opcode constants for the ALU request scheduler.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } sched_state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin search: first set request bit at or after ptr, with wrap.
module round_robin_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               any
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest set bit overwrites the rest.
    always_comb begin
        winner = ptr;
        any    = 1'b0;
        idx    = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[IDX_W'(idx)]) begin
                winner = IDX_W'(idx);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_request_scheduler.sv
// Shares one ALU control unit between NUM_REQ requesters with round-robin grant,
// a per-requester response channel and a watchdog for operations that never finish.
module alu_request_scheduler
    import alu_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    parameter  int TIMEOUT = 63,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [2*NUM_REQ-1:0]  req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [2*DATA_W-1:0]   resp_result,
    output logic                  resp_err,
    output logic                  alu_start,
    output logic [1:0]            alu_op_codes,
    output logic [DATA_W-1:0]     alu_a,
    output logic [DATA_W-1:0]     alu_b,
    input  logic                  alu_finish,
    input  logic [2*DATA_W-1:0]   alu_result,
    output logic                  busy,
    output logic [IDX_W-1:0]      grant_id
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    sched_state_t     state, state_next;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [CNT_W-1:0] wd_cnt;
    logic             timeout_hit;

    round_robin_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req    (req_valid),
        .ptr    (ptr),
        .winner (pick_idx),
        .any    (pick_any)
    );

    assign timeout_hit = (wd_cnt == CNT_W'(TIMEOUT));
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // req_ready is gated by reset so nothing is acknowledged while the block is held in reset.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        resp_valid = '0;
        alu_start  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any && rst) begin
                    req_ready[pick_idx] = 1'b1;
                    state_next          = ISSUE;
                end
            end
            ISSUE: begin
                alu_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (alu_finish || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid[grant_id] = 1'b1;
                if (resp_ready[grant_id]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Finish is checked before the timeout so a result arriving on the last cycle is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr          <= '0;
            grant_id     <= '0;
            alu_op_codes <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            resp_result  <= '0;
            resp_err     <= 1'b0;
            wd_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        alu_op_codes <= req_op[int'(pick_idx) * 2 +: 2];
                        alu_a        <= req_a[int'(pick_idx) * DATA_W +: DATA_W];
                        alu_b        <= req_b[int'(pick_idx) * DATA_W +: DATA_W];
                        grant_id     <= pick_idx;
                    end
                end
                ISSUE: wd_cnt <= '0;
                WAIT: begin
                    if (alu_finish) begin
                        resp_result <= alu_result;
                        resp_err    <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_result <= '0;
                        resp_err    <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready[grant_id]) begin
                        ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_request_scheduler.sv
// Self-checking bench: vector table of single operations, a fairness run and a mid-operation reset,
// with a behavioural ALU model and a response scoreboard.
module tb_alu_request_scheduler;
    import alu_sched_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 63;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_ready;
    logic [15:0] resp_result;
    logic        resp_err;
    logic        alu_start;
    logic [1:0]  alu_op_codes;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_finish = 1'b0;
    logic [15:0] alu_result = 16'hBEEF;
    logic        busy;
    logic [1:0]  grant_id;

    typedef struct {
        int          id;
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        int          lat;
        bit          hang;
        bit          glitch;
        int          bp;
        logic [3:0]  others;
        logic [15:0] exp_result;
        logic        exp_err;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] result;
        logic        err;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];
    int   vectors_applied = 0;
    int   miscompares     = 0;
    int   cyc             = 0;

    int   alu_lat    = 1;
    bit   alu_hang   = 1'b0;
    bit   alu_glitch = 1'b0;
    int   alu_cnt    = 0;

    alu_request_scheduler #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_result  (resp_result),
        .resp_err     (resp_err),
        .alu_start    (alu_start),
        .alu_op_codes (alu_op_codes),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_finish   (alu_finish),
        .alu_result   (alu_result),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model_result(logic [1:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            OP_ADD:  return {8'h00, a} + {8'h00, b};
            OP_SUB:  return {8'h00, a} - {8'h00, b};
            OP_MUL:  return {8'h00, a} * {8'h00, b};
            default: return (b == 8'h00) ? 16'hFFFF : {a % b, a / b};
        endcase
    endfunction

    // ALU model: finish lat cycles after the start cycle, reading operands only when it finishes.
    always begin
        @(posedge clk);
        #1;
        alu_finish = 1'b0;
        alu_result = 16'hBEEF;
        if (!rst) begin
            alu_cnt = 0;
        end else if (alu_start) begin
            alu_cnt = alu_hang ? 0 : alu_lat;
            if (alu_glitch) begin
                alu_finish = 1'b1;
                alu_result = 16'hDEAD;
            end
        end else if (alu_cnt > 0) begin
            alu_cnt = alu_cnt - 1;
            if (alu_cnt == 0) begin
                alu_finish = 1'b1;
                alu_result = model_result(alu_op_codes, alu_a, alu_b);
            end
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_edge();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkResponse();
        exp_t e;
        if (sb.size() == 0) begin
            vectors_applied++;
            miscompares++;
            $display("[TB] FAIL resp_unexpected: got resp_valid 0x%0h, want no response", resp_valid);
        end else begin
            e = sb.pop_front();
            checkOutput("resp_valid", 32'(resp_valid), 32'(4'b0001 << e.id));
            checkOutput("resp_result", 32'(resp_result), 32'(e.result));
            checkOutput("resp_err", 32'(resp_err), 32'(e.err));
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int  t;
        int  waited;
        bit  hold_ok;
        drive_edge();
        alu_lat    = v.lat;
        alu_hang   = v.hang;
        alu_glitch = v.glitch;
        req_op[v.id*2 +: 2] = v.op;
        req_a[v.id*8 +: 8]  = v.a;
        req_b[v.id*8 +: 8]  = v.b;
        req_valid  = (4'b0001 << v.id) | v.others;
        sb.push_back('{v.id, v.exp_result, v.exp_err});
        waited = 0;
        sample_edge();
        while (req_ready == 4'b0000 && waited < 20) begin
            drive_edge();
            sample_edge();
            waited++;
        end
        checkOutput("grant", 32'(req_ready), 32'(4'b0001 << v.id));
        t = cyc;
        drive_edge();
        req_valid = 4'b0000;
        sample_edge();
        checkOutput("start_busy", 32'({alu_start, busy}), 32'd3);
        checkOutput("alu_operands", 32'({grant_id, alu_op_codes, alu_a, alu_b}), 32'({2'(v.id), v.op, v.a, v.b}));
        drive_edge();
        sample_edge();
        checkOutput("start_once", 32'(alu_start), 32'd0);
        waited = 0;
        while (resp_valid == 4'b0000 && waited < TIMEOUT + 80) begin
            drive_edge();
            sample_edge();
            waited++;
        end
        checkOutput("resp_cycle", 32'(cyc), 32'(v.hang ? t + 3 + TIMEOUT : t + 2 + v.lat));
        checkResponse();
        hold_ok = 1'b1;
        for (int k = 0; k < v.bp; k++) begin
            drive_edge();
            resp_ready = ~(4'b0001 << v.id);
            req_valid  = ~(4'b0001 << v.id);
            sample_edge();
            if (resp_valid != (4'b0001 << v.id) || resp_result != v.exp_result ||
                !busy || req_ready != 4'b0000)
                hold_ok = 1'b0;
        end
        if (v.bp > 0) checkOutput("bp_hold", 32'(hold_ok), 32'd1);
        drive_edge();
        req_valid  = 4'b0000;
        resp_ready = 4'b0001 << v.id;
        sample_edge();
        drive_edge();
        resp_ready = 4'b0000;
        sample_edge();
        checkOutput("idle_after_ack", 32'({busy, resp_valid}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int waited;
        int last_resp;
        int id;
        vec_t rv;

        vecs[0] = '{0, OP_ADD, 8'h05, 8'h03, 10, 1'b0, 1'b0, 0,  4'h0, 16'h0008, 1'b0};
        vecs[1] = '{1, OP_SUB, 8'h10, 8'h03, 3,  1'b0, 1'b0, 0,  4'h0, 16'h000D, 1'b0};
        vecs[2] = '{2, OP_MUL, 8'h0C, 8'h0B, 5,  1'b0, 1'b0, 20, 4'h0, 16'h0084, 1'b0};
        vecs[3] = '{3, OP_DIV, 8'h64, 8'h07, 7,  1'b0, 1'b0, 0,  4'h0, 16'h020E, 1'b0};
        vecs[4] = '{1, OP_ADD, 8'h10, 8'h05, 12, 1'b0, 1'b1, 0,  4'h0, 16'h0015, 1'b0};
        vecs[5] = '{2, OP_MUL, 8'hFF, 8'hFF, 4,  1'b0, 1'b0, 0,  4'h0, 16'hFE01, 1'b0};
        vecs[6] = '{0, OP_SUB, 8'h03, 8'h05, 2,  1'b0, 1'b0, 0,  4'h0, 16'hFFFE, 1'b0};
        vecs[7] = '{3, OP_ADD, 8'h00, 8'h00, 0,  1'b1, 1'b0, 0,  4'h0, 16'h0000, 1'b1};
        vecs[8] = '{3, OP_ADD, 8'hFF, 8'h01, 1,  1'b0, 1'b0, 0,  4'h0, 16'h0100, 1'b0};
        vecs[9] = '{2, OP_MUL, 8'h02, 8'h03, 64, 1'b0, 1'b0, 0,  4'h0, 16'h0006, 1'b0};

        req_valid  = 4'b0000;
        resp_ready = 4'b0000;
        req_op     = 8'h00;
        req_a      = 32'h0;
        req_b      = 32'h0;
        rst        = 1'b0;
        repeat (3) drive_edge();
        checkOutput("reset_ctrl", 32'({busy, alu_start, req_ready, resp_valid, resp_err, grant_id}), 32'd0);
        checkOutput("reset_data", 32'({alu_op_codes, alu_a, alu_b}), 32'd0);
        checkOutput("reset_result", 32'(resp_result), 32'd0);
        rst = 1'b1;

        // Fairness: all requesters valid, grants must rotate and re-grant right after each ack.
        drive_edge();
        req_op     = {OP_DIV, OP_MUL, OP_SUB, OP_ADD};
        req_a      = {8'd40, 8'd30, 8'd20, 8'd10};
        req_b      = {8'd4, 8'd3, 8'd2, 8'd1};
        alu_lat    = 2;
        alu_hang   = 1'b0;
        alu_glitch = 1'b0;
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        last_resp  = 0;
        for (int k = 0; k < 8; k++) begin
            id = k % 4;
            sb.push_back('{id, model_result(req_op[id*2 +: 2], req_a[id*8 +: 8], req_b[id*8 +: 8]), 1'b0});
            waited = 0;
            sample_edge();
            while (req_ready == 4'b0000 && waited < 20) begin
                drive_edge();
                sample_edge();
                waited++;
            end
            checkOutput("rr_grant", 32'(req_ready), 32'(4'b0001 << id));
            if (k > 0) checkOutput("rr_regrant_cycle", 32'(cyc), 32'(last_resp + 1));
            waited = 0;
            while (resp_valid == 4'b0000 && waited < 40) begin
                drive_edge();
                sample_edge();
                waited++;
            end
            last_resp = cyc;
            checkResponse();
            drive_edge();
        end
        req_valid  = 4'b0000;
        resp_ready = 4'b0000;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset during WAIT: outputs clear at once, pointer restarts at 0, no response is owed.
        drive_edge();
        alu_hang    = 1'b1;
        alu_glitch  = 1'b0;
        req_op[3:2] = OP_MUL;
        req_a[15:8] = 8'h33;
        req_b[15:8] = 8'h44;
        req_valid   = 4'b0010;
        waited = 0;
        sample_edge();
        while (req_ready == 4'b0000 && waited < 20) begin
            drive_edge();
            sample_edge();
            waited++;
        end
        checkOutput("rst_pre_grant", 32'(req_ready), 32'h2);
        drive_edge();
        req_valid = 4'b0000;
        drive_edge();
        drive_edge();
        rst       = 1'b0;
        req_valid = 4'b1010;
        #1;
        checkOutput("rst_ctrl", 32'({busy, alu_start, req_ready, resp_valid, resp_err, grant_id}), 32'd0);
        checkOutput("rst_data", 32'({alu_op_codes, alu_a, alu_b}), 32'd0);
        checkOutput("rst_result", 32'(resp_result), 32'd0);
        sb.delete();
        drive_edge();
        rst       = 1'b1;
        req_valid = 4'b0000;
        rv = '{1, OP_SUB, 8'h09, 8'h04, 3, 1'b0, 1'b0, 0, 4'b1000, 16'h0005, 1'b0};
        applyStimulus(rv);

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_request_scheduler.md
# alu_request_scheduler

Shares the single ALU and its control unit (add/sub/Booth multiply/divide sequencer) between `NUM_REQ` requesters. Round-robin arbitration picks one requester, latches its opcode and operands, and pulses `alu_start`. It then waits for the ALU's `finish`, captures the result and returns it over a per-requester valid/ready response channel. A watchdog ends any operation whose `finish` never arrives.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: operand width; the result is 2*DATA_W.
- `TIMEOUT`, 63: maximum WAIT cycles before abort, ≥ 16.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_ready`  out  NUM_REQ  request accepted this cycle; one-hot or zero.
- `req_op`  in  2*NUM_REQ  per-requester opcode: 0 add, 1 sub, 2 mul, 3 div.
- `req_a`, `req_b`  in  DATA_W*NUM_REQ  per-requester operands.
- `resp_valid`  out  NUM_REQ  response available; one-hot or zero.
- `resp_ready`  in  NUM_REQ  requester takes the response.
- `resp_result`  out  2*DATA_W  result, shared bus, qualified by `resp_valid`.
- `resp_err`  out  1  response is a timeout abort; qualified by `resp_valid`.
- `alu_start`  out  1  one-cycle start pulse to the ALU control unit.
- `alu_op_codes`  out  2  opcode to the ALU.
- `alu_a`, `alu_b`  out  DATA_W  operands to the ALU.
- `alu_finish`  in  1  ALU control unit finish.
- `alu_result`  in  2*DATA_W  ALU result; valid when `alu_finish` is high.
- `busy`  out  1  state is not IDLE.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last granted requester.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - The winner is the first set bit of `req_valid`, searching from `ptr` upward with wrap.
  - `req_ready[winner]` is asserted combinationally.
  - On that handshake: latch opcode and operands into the `alu_*` holding registers, set `grant_id` to the winner, go to ISSUE.
- **ISSUE**
  - `alu_start` = 1 for exactly this cycle.
  - Clear the watchdog counter.
  - Go to WAIT.
  - `alu_finish` in this cycle is ignored; it is a leftover from a previous operation.
- **WAIT**
  - The watchdog counter increments each cycle.
  - On `alu_finish`: capture `alu_result` into `resp_result`, clear `resp_err`, go to RESP.
  - Otherwise, if the counter reaches `TIMEOUT`: set `resp_result` = 0 and `resp_err` = 1, go to RESP.
  - If `alu_finish` and the timeout occur in the same cycle, `alu_finish` wins.
- **RESP**
  - `resp_valid[grant_id]` = 1; `resp_result` and `resp_err` are held.
  - On `resp_ready[grant_id]`: go to IDLE and set `ptr` = (grant_id+1) mod NUM_REQ.
  - `resp_ready` bits of other requesters are ignored.
- `alu_op_codes`, `alu_a` and `alu_b` stay stable from ISSUE through RESP; the ALU samples operands after start.
- A requester may drop `req_valid` before it is granted; no state changes.
- No new request is accepted while `busy` is high; at most one operation is outstanding.
- Reset values:
  - state IDLE, `ptr` = 0, `grant_id` = 0.
  - All `req_ready`, `resp_valid`, `alu_start`, `resp_err` = 0.
  - `alu_*`, `resp_result` and the counter = 0.
- Reset mid-operation: everything returns to reset values immediately and no response is produced. The ALU shares `rst`, so it aborts too.

## Timing
- Handshake at cycle T: `alu_start` is high in T+1, WAIT begins at T+2.
- `alu_finish` at cycle F ≥ T+2: `resp_valid` is high from F+1.
- Timeout: `resp_valid` is high at T+2+TIMEOUT+1 when no finish arrives.
- Response accepted at R: IDLE at R+1, where the next grant can occur, so `req_ready` is high at R+1.
- Minimum request-to-response interval: 3 cycles plus the ALU latency.
- Fairness: with all requesters valid continuously, grants rotate 0,1,2,3,0,…

## Structure
- Package `alu_sched_pkg`:
  - state enum `sched_state_t` {IDLE, ISSUE, WAIT, RESP}.
  - opcode constants `OP_ADD`=2'd0, `OP_SUB`=2'd1, `OP_MUL`=2'd2, `OP_DIV`=2'd3.
- Sub-module `round_robin_picker`:
  - Inputs: `req` vector and `ptr`.
  - Outputs: `winner` index and `any`.
  - Purely combinational; the scheduler owns `ptr` and the FSM.

## Test plan
1. Requester 0 only: op=0, a=8'h05, b=8'h03; ALU model asserts `finish` with result 16'h0008 after 10 cycles → `alu_start` pulses once at T+1; `resp_valid[0]` at F+1 with `resp_result`=16'h0008, `resp_err`=0.
2. `req_valid`=4'b1111 held through 8 operations → grant order 0,1,2,3,0,1,2,3; `req_ready` is one-hot in each IDLE handshake cycle.
3. Backpressure: `resp_ready[2]` held low for 20 cycles → `resp_valid[2]` and `resp_result` stable, `busy`=1, no new `req_ready`; `ready` at cycle R → IDLE at R+1.
4. ALU model pulses `finish` during ISSUE and again 12 cycles later with 16'h0015 → first pulse ignored, `resp_result`=16'h0015.
5. ALU never finishes, TIMEOUT=63 → `resp_valid` at T+66 with `resp_err`=1 and `resp_result`=0; the next request is accepted normally.
6. `rst` asserted low during WAIT → all outputs at reset values in the same cycle; after release, a request from requester 1 is granted first with `ptr`=0 search order.
